// File: rtl/handshake_pkg.sv
// Shared handshake types for the dataless FIFO and the non-deterministic wire.
package handshake_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  typedef enum logic {
    SLEEPING = 1'b0,
    RUNNING  = 1'b1
  } nd_state_t;

  // Occupancy class implied by a count; used to cross-check the state register.
  function automatic fifo_state_t state_of_count(input int unsigned cnt, input int unsigned max);
    if (cnt == 0) begin
      return EMPTY;
    end else if (cnt == max) begin
      return FULL;
    end else begin
      return PARTIAL;
    end
  endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Saturating up/down counter holding the FIFO occupancy (0..MAX).
module occupancy_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         is_zero,
  output logic         is_max
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_max  = (cnt_q == W'(MAX));

  // Next count: simultaneous inc/dec cancel; saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !is_max) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elastic_fifo_dataless.sv
// Dataless elastic FIFO: tracks up to NUM_SLOTS handshake tokens as a count.
// Both valid and ready come from registered state only, so there is no
// combinational path between the two sides.
// Optional macro ELASTIC_FIFO_DATALESS_ASSERT_EN compiles in protocol assertions.
module elastic_fifo_dataless
  import handshake_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ins_valid,
  output logic             ins_ready,
  output logic             outs_valid,
  input  logic             outs_ready,
  output logic [CNT_W-1:0] count
);

  if (NUM_SLOTS < 1) begin : g_bad_slots
    $error("elastic_fifo_dataless: NUM_SLOTS must be >= 1");
  end

  logic        in_xfer, out_xfer;
  logic        cnt_zero, cnt_max;
  fifo_state_t state_q, state_d;

  occupancy_counter #(
    .MAX (NUM_SLOTS),
    .W   (CNT_W)
  ) u_occupancy_counter (
    .clk     (clk),
    .rst     (rst),
    .inc     (in_xfer),
    .dec     (out_xfer),
    .cnt     (count),
    .is_zero (cnt_zero),
    .is_max  (cnt_max)
  );

  // Refusing input while full even if the downstream drains this cycle keeps
  // ins_ready independent of outs_ready.
  assign ins_ready  = !rst && !cnt_max;
  assign outs_valid = !cnt_zero;
  assign in_xfer    = ins_valid && ins_ready;
  assign out_xfer   = outs_valid && outs_ready;

  // Next-state: follows the occupancy class of the count after this edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = (NUM_SLOTS == 1) ? FULL : PARTIAL;
        end
      end
      PARTIAL: begin
        if (in_xfer && !out_xfer && (count == CNT_W'(NUM_SLOTS - 1))) begin
          state_d = FULL;
        end else if (out_xfer && !in_xfer && (count == CNT_W'(1))) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d = (NUM_SLOTS == 1) ? EMPTY : PARTIAL;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register, reset alongside the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef ELASTIC_FIFO_DATALESS_ASSERT_EN
  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(NUM_SLOTS));

  a_state_match : assert property (@(posedge clk) disable iff (rst)
    state_q == state_of_count(32'(count), NUM_SLOTS));

  a_outs_hold : assert property (@(posedge clk) disable iff (rst)
    outs_valid && !outs_ready |=> outs_valid);

  m_ins_hold : assume property (@(posedge clk) disable iff (rst)
    ins_valid && !ins_ready |=> ins_valid);

  a_no_xfer_in_rst : assert property (@(posedge clk)
    rst |-> !in_xfer && !out_xfer);
`endif

endmodule

// File: doc/elastic_fifo_dataless.md
# elastic_fifo_dataless

Dataless elastic FIFO that stores up to NUM_SLOTS handshake tokens as an occupancy count. It sits directly upstream of ndwire_dataless in formal and simulation harnesses. It absorbs the random stalls the non-deterministic wire injects. It decouples both valid and ready: there is no combinational path from input to output in either direction.

## Interface
- NUM_SLOTS, default 4: token capacity. Must be ≥ 1; any other value is an elaboration error.
- CNT_W, default $clog2(NUM_SLOTS+1): width of the occupancy count. Derived; never overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ins_valid  input  1  upstream offers a token.
- ins_ready  output  1  FIFO accepts a token this cycle.
- outs_valid  output  1  FIFO offers a token downstream.
- outs_ready  input  1  downstream accepts the token.
- count  output  CNT_W  current occupancy, 0..NUM_SLOTS.

## Operation
- Input transfer: ins_valid && ins_ready. Output transfer: outs_valid && outs_ready.
- count update per cycle:
  - +1 on input transfer only.
  - −1 on output transfer only.
  - Unchanged on both or neither.
- outs_valid = (count != 0). Derived from registered state only.
- ins_ready = !rst && (count != NUM_SLOTS). Derived from registered state only; no dependence on outs_ready.
- State (package enum fifo_state_t), held in a register alongside count:
  - EMPTY: count = 0.
  - PARTIAL: 0 < count < NUM_SLOTS.
  - FULL: count = NUM_SLOTS.
  - For NUM_SLOTS = 1, PARTIAL is unreachable.
- Transitions:
  - EMPTY→PARTIAL (or →FULL when NUM_SLOTS = 1) on input transfer.
  - PARTIAL→FULL on input-only transfer at count = NUM_SLOTS−1.
  - PARTIAL→EMPTY on output-only transfer at count = 1.
  - FULL→PARTIAL (or →EMPTY when NUM_SLOTS = 1) on output transfer.
- State and count must agree every cycle.
- Boundary behaviour:
  - Full: input is refused even if outs_ready is high in the same cycle. A simultaneous drain frees the slot for the next cycle.
  - Empty: outs_valid is low; no fall-through.
  - Count never wraps. Overflow and underflow are structurally impossible because the handshake gates both.

## Timing
- Reset values: count = 0, state EMPTY, outs_valid = 0.
- ins_ready = 0 while rst is high. It rises combinationally when rst deasserts (count = 0).
- Reset mid-operation discards all stored tokens immediately; outs_valid drops asynchronously.
- Latency: a token accepted at edge N is offered (outs_valid = 1) in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput:
  - 1 token/cycle sustained for NUM_SLOTS ≥ 2.
  - 1 token per 2 cycles for NUM_SLOTS = 1.
- outs_valid, once high, stays high until an output transfer. Tokens are never retracted.
- The upstream is required to hold ins_valid until transfer.

## Configuration
- ELASTIC_FIFO_DATALESS_ASSERT_EN defined: protocol assertions are compiled in:
  - count ≤ NUM_SLOTS.
  - The state encoding matches count.
  - outs_valid persists until outs_ready.
  - ins_valid stable until ins_ready (assume-style, for formal).
  - No transfers while rst is high.
- Undefined: no assertion code is present. Functional behaviour is identical bit-for-bit.

## Structure
- Shared package handshake_pkg holds:
  - typedef enum fifo_state_t {EMPTY, PARTIAL, FULL}.
  - nd_state_t {SLEEPING, RUNNING}, moved there from the wire so harnesses can reference both.
- One sub-module, occupancy_counter: a saturating up/down counter with parameters MAX and W, inputs inc/dec, and outputs cnt, is_zero and is_max. The FIFO top holds only handshake logic and the state register.

## Test plan
- Reset, then NUM_SLOTS = 4 with ins_valid = 1 and outs_ready = 0 for 6 cycles:
  - Exactly 4 transfers.
  - count = 4, state FULL, ins_ready = 0 from cycle 4.
- From full, set outs_ready = 1 with ins_valid = 0:
  - outs_valid high for exactly 4 cycles.
  - count goes 3, 2, 1, 0, then outs_valid = 0.
- NUM_SLOTS = 4, both sides always ready, 20 tokens:
  - After the first accept, 1 output per cycle.
  - count stays at 1; 20 outputs total.
- NUM_SLOTS = 1, both sides always ready, 10 tokens → 10 outputs over 20 cycles; count alternates 1/0.
- Feed into ndwire_dataless with random outs_ready, 1000 cycles:
  - Tokens in = tokens out + final count.
  - No assertion fires with ELASTIC_FIFO_DATALESS_ASSERT_EN defined.
- Assert rst for 1 cycle at count = 3:
  - count = 0, outs_valid = 0 immediately, ins_ready = 0 during rst.
  - Normal accept resumes the cycle after deassertion.
